// File: rtl/cb_out_fifo.sv
// Output buffer between the connection box and the PE core: either a combinational bypass or a small FWFT FIFO.
// Define CB_OUT_FIFO_STATS_EN to add a saturating drop counter readable at CFG_ADDR+1.
module cb_out_fifo #(
    parameter int         WIDTH    = 7,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] CFG_ADDR = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              config_addr,
    input  logic [31:0]              config_data,
    input  logic                     config_en,
    output logic [31:0]              read_data,
    input  logic [WIDTH-1:0]         in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mode_q, mode_d;
    logic [3:0]       af_thresh_q, af_thresh_d;

    logic [7:0] addr8;
    logic       cfg_wr;
    logic       flush;
    logic       not_full;
    logic       not_empty;
    logic       push;
    logic       pop;
    logic       cfg_unused;

    assign addr8      = config_addr[7:0];
    assign cfg_wr     = config_en && (addr8 == CFG_ADDR);
    assign flush      = cfg_wr && (config_data[1] || (config_data[0] != mode_q));
    assign cfg_unused = ^{config_addr[31:8], config_data[31:12], config_data[7:2]};

    assign not_full  = (count_q != CW'(DEPTH));
    assign not_empty = (count_q != '0);

    // Bypass is purely combinational; the FIFO path never passes data through when empty or full.
    assign in_ready  = mode_q ? not_full  : out_ready;
    assign out_valid = mode_q ? not_empty : in_valid;
    assign out       = mode_q ? mem_q[rd_ptr_q] : in;

    assign push = mode_q && in_valid && not_full;
    assign pop  = mode_q && not_empty && out_ready;

    assign count       = count_q;
    assign almost_full = mode_q && (32'(count_q) >= 32'(af_thresh_q));

    always_comb begin
        mode_d      = mode_q;
        af_thresh_d = af_thresh_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A flush overrides any handshake in the same cycle, but the ctrl write still lands.
        if (cfg_wr) begin
            mode_d      = config_data[0];
            af_thresh_d = config_data[11:8];
            if (flush) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= 1'b0;
            af_thresh_q <= 4'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            af_thresh_q <= af_thresh_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

`ifdef CB_OUT_FIFO_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic        stats_wr;

    assign stats_wr = config_en && (addr8 == (CFG_ADDR + 8'd1));

    always_comb begin
        drop_d = drop_q;
        if (flush || stats_wr) begin
            drop_d = 16'd0;
        end else if (mode_q && in_valid && !not_full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end
`endif

    always_comb begin
        read_data = 32'd0;
        if (addr8 == CFG_ADDR) begin
            read_data[23:16] = 8'(count_q);
            read_data[11:8]  = af_thresh_q;
            read_data[0]     = mode_q;
        end
`ifdef CB_OUT_FIFO_STATS_EN
        else if (addr8 == (CFG_ADDR + 8'd1)) begin
            read_data[15:0] = drop_q;
        end
`endif
    end

endmodule

// File: tb/tb_cb_out_fifo.sv
// Bench for cb_out_fifo: bypass vector table plus scoreboarded FIFO sequences.
module tb_cb_out_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic [31:0] read_data;
    logic [6:0]  in;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        almost_full;

    cb_out_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .read_data   (read_data),
        .in          (in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] inData;
        logic       inValid;
        logic       outReady;
        logic [6:0] expOut;
        logic       expValid;
        logic       expReady;
    } vec_t;

    vec_t       vecs [6];
    int         vecCount  = 0;
    int         failCount = 0;
    logic [6:0] model [$];
    logic       mode;
    logic [3:0] af;
    int         drop;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle: compare against the model, then advance model and DUT together.
    task automatic applyStimulus(input logic [6:0] d, input logic v, input logic r);
        int          n;
        logic        expReady;
        logic        expValid;
        logic [31:0] expRd;
        in          = d;
        in_valid    = v;
        out_ready   = r;
        config_en   = 1'b0;
        config_addr = 32'd0;
        config_data = 32'd0;
        #1;
        n        = model.size();
        expReady = mode ? (n != 4) : r;
        expValid = mode ? (n != 0) : v;
        expRd    = {8'd0, 8'(n), 4'd0, af, 7'd0, mode};
        checkOutput("in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        checkOutput("count", 32'(count), 32'(n));
        checkOutput("almost_full", 32'(almost_full), 32'(mode && (n >= int'(af))));
        checkOutput("read_data", read_data, expRd);
        if (!mode) begin
            checkOutput("out_bypass", 32'(out), 32'(d));
        end else if (expValid) begin
            checkOutput("out_fifo", 32'(out), 32'(model[0]));
        end
        if (mode) begin
            if (v && !expReady && drop != 16'hFFFF) begin
                drop++;
            end
            if (expValid && r) begin
                void'(model.pop_front());
            end
            if (v && expReady) begin
                model.push_back(d);
            end
        end
        tick();
    endtask

    task automatic cfgWrite(input logic [7:0] addr, input logic [31:0] data);
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        config_addr = {24'd0, addr};
        config_data = data;
        config_en   = 1'b1;
        if (addr == 8'd0) begin
            if (data[1] || (data[0] != mode)) begin
                model.delete();
                drop = 0;
            end
            mode = data[0];
            af   = data[11:8];
        end else if (addr == 8'd1) begin
            drop = 0;
        end
        tick();
        config_en   = 1'b0;
        config_addr = 32'd0;
        config_data = 32'd0;
    endtask

    task automatic checkDrop();
        int expDrop;
`ifdef CB_OUT_FIFO_STATS_EN
        expDrop = drop;
`else
        expDrop = 0;
`endif
        config_en   = 1'b0;
        config_addr = 32'd1;
        #1;
        checkOutput("drop_readback", read_data, 32'(expDrop));
        config_addr = 32'd0;
    endtask

    task automatic runBypassTable();
        for (int i = 0; i < 6; i++) begin
            in        = vecs[i].inData;
            in_valid  = vecs[i].inValid;
            out_ready = vecs[i].outReady;
            #1;
            checkOutput("tbl_out", 32'(out), 32'(vecs[i].expOut));
            checkOutput("tbl_out_valid", 32'(out_valid), 32'(vecs[i].expValid));
            checkOutput("tbl_in_ready", 32'(in_ready), 32'(vecs[i].expReady));
            checkOutput("tbl_count", 32'(count), 32'd0);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{7'd4,   1'b1, 1'b1, 7'd4,   1'b1, 1'b1};
        vecs[1] = '{7'd127, 1'b1, 1'b0, 7'd127, 1'b1, 1'b0};
        vecs[2] = '{7'd0,   1'b0, 1'b1, 7'd0,   1'b0, 1'b1};
        vecs[3] = '{7'd85,  1'b0, 1'b0, 7'd85,  1'b0, 1'b0};
        vecs[4] = '{7'd42,  1'b1, 1'b1, 7'd42,  1'b1, 1'b1};
        vecs[5] = '{7'd1,   1'b1, 1'b0, 7'd1,   1'b1, 1'b0};

        mode        = 1'b0;
        af          = 4'd0;
        drop        = 0;
        reset       = 1'b0;
        config_en   = 1'b0;
        config_addr = 32'd0;
        config_data = 32'd0;
        in          = 7'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Bypass after reset
        applyStimulus(7'd4, 1'b1, 1'b1);
        runBypassTable();
        checkDrop();

        // Fill to full, then reject a push
        cfgWrite(8'd0, 32'h0000_0301);
        applyStimulus(7'd5, 1'b1, 1'b0);
        applyStimulus(7'd6, 1'b1, 1'b0);
        applyStimulus(7'd7, 1'b1, 1'b0);
        applyStimulus(7'd8, 1'b1, 1'b0);
        applyStimulus(7'd9, 1'b1, 1'b0);
        checkDrop();

        // Pop while full, then simultaneous push/pop, then drain across the wrap
        applyStimulus(7'd10, 1'b1, 1'b1);
        applyStimulus(7'd10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7'd0, 1'b0, 1'b1);
        end
        checkDrop();
        cfgWrite(8'd1, 32'd0);
        checkDrop();

        // Flush with two entries held, zero threshold, back to bypass
        applyStimulus(7'd21, 1'b1, 1'b0);
        applyStimulus(7'd22, 1'b1, 1'b0);
        cfgWrite(8'd0, 32'h0000_0303);
        applyStimulus(7'd0, 1'b0, 1'b0);
        cfgWrite(8'd0, 32'h0000_0001);
        applyStimulus(7'd30, 1'b1, 1'b0);
        applyStimulus(7'd0, 1'b0, 1'b1);
        cfgWrite(8'd0, 32'h0000_0000);
        runBypassTable();

        // Reset in the middle of a stream
        cfgWrite(8'd0, 32'h0000_0301);
        applyStimulus(7'd1, 1'b1, 1'b0);
        applyStimulus(7'd2, 1'b1, 1'b0);
        applyStimulus(7'd3, 1'b1, 1'b0);
        in          = 7'd9;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        config_addr = 32'd0;
        reset       = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
        checkOutput("rst_read_data", read_data, 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd1);
        checkOutput("rst_out", 32'(out), 32'd9);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        model.delete();
        mode = 1'b0;
        af   = 4'd0;
        drop = 0;
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(7'd55, 1'b1, 1'b1);
        checkDrop();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
